// File: rtl/or4_tester_pkg.sv
// Shared types and widths for the quad OR-gate self-test sequencer.
package or4_tester_pkg;

  localparam int VEC_W = 8;
  localparam int ERR_W = 9;
  localparam int Y_W   = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_e;

  // Reference response of a healthy gate stage for the vector {A,B}.
  function automatic logic [Y_W-1:0] or_ref(input logic [VEC_W-1:0] vec);
    return vec[VEC_W-1:Y_W] | vec[Y_W-1:0];
  endfunction

endpackage

// File: rtl/or4_gate_tester_if.sv
// Bundle between the tester and the gate-under-test environment.
interface or4_gate_tester_if;
  import or4_tester_pkg::*;

  logic               start;
  logic [Y_W-1:0]     a;
  logic [Y_W-1:0]     b;
  logic [Y_W-1:0]     y_in;
  logic               busy;
  logic               done;
  logic               pass;
  logic [ERR_W-1:0]   err_cnt;
  logic               fail_valid;
  logic [VEC_W-1:0]   fail_vec;

  modport master (
    input  start, y_in,
    output a, b, busy, done, pass, err_cnt, fail_valid, fail_vec
  );

  modport slave (
    output start, y_in,
    input  a, b, busy, done, pass, err_cnt, fail_valid, fail_vec
  );

endinterface

// File: rtl/or4_gate_tester_sync_2ff.sv
// Two-flop synchroniser for a bus that is asynchronous to clk_i.
module sync_2ff #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/or4_gate_tester.sv
// Sweeps all 256 {A,B} vectors through the OR stage, holding each for SETTLE_CYCLES
// then checking the synchronised Y; reports error count, first failing vector, pass/fail.
module or4_gate_tester
  import or4_tester_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  or4_gate_tester_if.master bus
);

  localparam logic [3:0] WAIT_LAST = 4'(SETTLE_CYCLES - 1);

  state_e           state_q, state_d;
  logic [VEC_W-1:0] vec_q, vec_d;
  logic [3:0]       wait_q, wait_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic             fail_valid_q, fail_valid_d;
  logic [VEC_W-1:0] fail_vec_q, fail_vec_d;
  logic [VEC_W-1:0] ab_q, ab_d;
  logic [Y_W-1:0]   y_s;
  logic             start_acc;
  logic             mismatch;

  sync_2ff #(.W(Y_W)) u_y_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (bus.y_in),
    .q_o   (y_s)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      vec_q        <= '0;
      wait_q       <= '0;
      err_cnt_q    <= '0;
      fail_valid_q <= 1'b0;
      fail_vec_q   <= '0;
      ab_q         <= '0;
    end else begin
      state_q      <= state_d;
      vec_q        <= vec_d;
      wait_q       <= wait_d;
      err_cnt_q    <= err_cnt_d;
      fail_valid_q <= fail_valid_d;
      fail_vec_q   <= fail_vec_d;
      ab_q         <= ab_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (bus.start) state_d = SETTLE;
      SETTLE:     if (wait_q == WAIT_LAST) state_d = CHECK;
      CHECK:      state_d = (vec_q == {VEC_W{1'b1}}) ? DONE : SETTLE;
      default:    state_d = IDLE;
    endcase
  end

  assign start_acc = ((state_q == IDLE) || (state_q == DONE)) && bus.start;
  // Compare against the vector actually on the pins, not the counter.
  assign mismatch  = (state_q == CHECK) && (y_s != or_ref(ab_q));

  always_comb begin
    vec_d        = vec_q;
    wait_d       = wait_q;
    err_cnt_d    = err_cnt_q;
    fail_valid_d = fail_valid_q;
    fail_vec_d   = fail_vec_q;

    if (start_acc) begin
      vec_d        = '0;
      wait_d       = '0;
      err_cnt_d    = '0;
      fail_valid_d = 1'b0;
      fail_vec_d   = '0;
    end else if (state_q == SETTLE) begin
      wait_d = wait_q + 4'd1;
    end else if (state_q == CHECK) begin
      if (mismatch) begin
        err_cnt_d = err_cnt_q + ERR_W'(1);
        if (!fail_valid_q) begin
          fail_valid_d = 1'b1;
          fail_vec_d   = ab_q;
        end
      end
      if (vec_q != {VEC_W{1'b1}}) begin
        vec_d  = vec_q + VEC_W'(1);
        wait_d = '0;
      end
    end
  end

  // Operands are parked at zero whenever no sweep is in progress.
  always_comb begin
    ab_d = '0;
    if ((state_d == SETTLE) || (state_d == CHECK)) ab_d = vec_d;
  end

  always_comb begin
    bus.busy       = (state_q == SETTLE) || (state_q == CHECK);
    bus.done       = (state_q == DONE);
    bus.pass       = (state_q == DONE) && (err_cnt_q == '0);
    bus.a          = ab_q[VEC_W-1:Y_W];
    bus.b          = ab_q[Y_W-1:0];
    bus.err_cnt    = err_cnt_q;
    bus.fail_valid = fail_valid_q;
    bus.fail_vec   = fail_vec_q;
  end

endmodule

// File: tb/tb_or4_gate_tester.sv
// Scoreboarded bench for or4_gate_tester: fault-injecting gate model, sweep timing and interruptions.
module tb_or4_gate_tester;

  localparam int S   = 4;
  localparam int LAT = 256 * (S + 1);

  typedef struct {
    int          err;
    bit          fv;
    logic [7:0]  fvec;
    bit          pass;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   fault_mode = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  or4_gate_tester_if ifc ();

  or4_gate_tester #(.SETTLE_CYCLES(S)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (ifc)
  );

  // 0 healthy, 1 Y[2] stuck-at-0, 2 bit0 is AND, 3 bit0 wrong only at A=B=F
  function automatic logic [3:0] gate_model(input logic [3:0] a, input logic [3:0] b, input int mode);
    logic [3:0] y;
    y = a | b;
    case (mode)
      1: y[2] = 1'b0;
      2: y[0] = a[0] & b[0];
      3: if (a == 4'hF && b == 4'hF) y[0] = 1'b0;
      default: ;
    endcase
    return y;
  endfunction

  assign ifc.y_in = gate_model(ifc.a, ifc.b, fault_mode);

  function automatic exp_t predict(input int mode);
    exp_t e;
    logic [7:0] v;
    e.err = 0; e.fv = 1'b0; e.fvec = 8'h00; e.lat = LAT;
    for (int i = 0; i < 256; i++) begin
      v = i[7:0];
      if (gate_model(v[7:4], v[3:0], mode) != (v[7:4] | v[3:0])) begin
        e.err++;
        if (!e.fv) begin e.fv = 1'b1; e.fvec = v; end
      end
    end
    e.pass = (e.err == 0);
    return e;
  endfunction

  function automatic logic [28:0] outs_pack();
    return {ifc.a, ifc.b, ifc.busy, ifc.done, ifc.pass, ifc.err_cnt, ifc.fail_valid, ifc.fail_vec};
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  int t0;

  task automatic start_sweep(input int mode);
    @(negedge clk);
    fault_mode = mode;
    ifc.start  = 1'b1;
    sb.push_back(predict(mode));
    @(negedge clk);
    t0 = cyc;
    ifc.start = 1'b0;
    check_val("busy_after_start", {31'd0, ifc.busy}, 32'd1);
    check_val("done_low_after_start", {30'd0, ifc.done, ifc.pass}, 32'd0);
  endtask

  task automatic finish_sweep(input int p1, input int p2);
    exp_t e;
    bit   seen;
    int   lat;
    seen = 1'b0;
    lat  = 0;
    for (int n = 1; n <= LAT + 50; n++) begin
      @(negedge clk);
      ifc.start = (n == p1 || n == p2);
      if (ifc.done) begin
        seen = 1'b1;
        lat  = cyc - t0;
        break;
      end
    end
    ifc.start = 1'b0;
    e = sb.pop_front();
    if (!seen) begin
      check_val("done_timeout", 32'd0, 32'd1);
    end else begin
      check_val("done_latency", lat, e.lat);
      check_val("err_cnt", {23'd0, ifc.err_cnt}, e.err);
      check_val("fail_valid", {31'd0, ifc.fail_valid}, {31'd0, e.fv});
      check_val("fail_vec", {24'd0, ifc.fail_vec}, {24'd0, e.fvec});
      check_val("pass", {31'd0, ifc.pass}, {31'd0, e.pass});
      check_val("busy_in_done", {31'd0, ifc.busy}, 32'd0);
      check_val("ab_in_done", {24'd0, ifc.a, ifc.b}, 32'd0);
    end
  endtask

  int bad;

  initial begin
    rst = 1'b1;
    ifc.start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("reset_outputs", {3'd0, outs_pack()}, 32'd0);
    rst = 1'b0;

    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (outs_pack() != '0) bad++;
    end
    check_val("idle_stable", bad, 32'd0);

    start_sweep(0); finish_sweep(-1, -1);

    // results held in DONE
    repeat (20) @(negedge clk);
    check_val("done_held", {30'd0, ifc.done, ifc.pass}, 32'd3);

    start_sweep(1); finish_sweep(-1, -1);
    start_sweep(0); finish_sweep(-1, -1);
    start_sweep(2); finish_sweep(-1, -1);
    start_sweep(3); finish_sweep(100, 700);

    // reset mid-sweep
    @(negedge clk);
    fault_mode = 1;
    ifc.start  = 1'b1;
    @(negedge clk);
    ifc.start  = 1'b0;
    repeat (498) @(negedge clk);
    check_val("busy_before_rst", {31'd0, ifc.busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_val("rst_mid_sweep", {3'd0, outs_pack()}, 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check_val("idle_after_rst", {3'd0, outs_pack()}, 32'd0);

    start_sweep(0); finish_sweep(-1, -1);

    check_val("scoreboard_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
